multicycle_ctrl_fsm: RTL and testbench

//  Main control FSM for the sequential (multi-cycle) RV64I core. Sequences a single shared

---
 rtl/riscv_ctrl_pkg.sv | 53 +++++
 rtl/riscv_main_decoder.sv | 37 +++
 rtl/multicycle_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64I control path: FSM states, opcodes,
// funct fields, ALU op codes, the decoder result and the control-strobe bundle.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LDSD = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic is_ld;
        logic is_sd;
        logic is_rtype;
        logic is_beq;
        logic is_illegal;
    } dec_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic       pc_sel;
        logic       reg_we;
        logic       wb_sel;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/riscv_main_decoder.sv
// Combinational instruction classifier: recognises ld, sd, beq and the
// add/sub/and/or R-type subset; anything else is flagged illegal.
module riscv_main_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register and immediate fields do not affect classification.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dec = '0;
        case (opcode)
            OPC_LOAD:   dec.is_ld  = (funct3 == F3_LDSD);
            OPC_STORE:  dec.is_sd  = (funct3 == F3_LDSD);
            OPC_BRANCH: dec.is_beq = (funct3 == F3_BEQ);
            OPC_OP: begin
                dec.is_rtype = ((funct3 == F3_ADD) && (funct7 == F7_BASE || funct7 == F7_ALT))
                            || ((funct3 == F3_AND || funct3 == F3_OR) && funct7 == F7_BASE);
            end
            default: ;
        endcase
        dec.is_illegal = !(dec.is_ld || dec.is_sd || dec.is_rtype || dec.is_beq);
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV64I core: FETCH/DECODE/EXEC/MEM/WB with
// memory timeout and illegal-instruction traps plus a retired-instruction counter.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire;
    logic              timed_out;
    dec_t              dec;
    ctrl_t             ctrl;

    riscv_main_decoder u_decoder (
        .instr (instr),
        .dec   (dec)
    );

    assign timed_out = (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ctrl      = '0;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_we = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timed_out) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec.is_illegal) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.is_rtype) begin
                    ctrl.alu_op = ALU_FUNCT;
                    state_d     = ST_WB;
                end else if (dec.is_ld || dec.is_sd) begin
                    ctrl.alu_src = 1'b1;
                    state_d      = ST_MEM;
                end else if (dec.is_beq) begin
                    ctrl.alu_op = ALU_SUB;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = alu_zero;
                    retire      = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_MEM: begin
                ctrl.mem_req  = 1'b1;
                ctrl.addr_sel = 1'b1;
                ctrl.mem_we   = dec.is_sd;
                if (mem_ready) begin
                    if (dec.is_sd) begin
                        ctrl.pc_we = 1'b1;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timed_out) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_sel = dec.is_ld;
                ctrl.pc_we  = 1'b1;
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_TRAP;
        endcase
        // Strobes stay quiet while reset is held, even though the state reads FETCH.
        if (!rst_n) begin
            ctrl = '0;
        end
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    assign mem_req  = ctrl.mem_req;
    assign mem_we   = ctrl.mem_we;
    assign addr_sel = ctrl.addr_sel;
    assign ir_we    = ctrl.ir_we;
    assign pc_we    = ctrl.pc_we;
    assign pc_sel   = ctrl.pc_sel;
    assign reg_we   = ctrl.reg_we;
    assign wb_sel   = ctrl.wb_sel;
    assign alu_src  = ctrl.alu_src;
    assign alu_op   = ctrl.alu_op;
    assign state    = state_q;
    assign illegal  = illegal_q;
    assign bus_err  = bus_err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm: walks each instruction class
// cycle by cycle against hand-computed strobe bundles and state codes.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel;
    logic        reg_we, wb_sel, alu_src;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        illegal, bus_err;
    logic [31:0] retired;

    int n_vec = 0;
    int n_err = 0;

    // State codes
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

    // Strobe bundle: req we asel irwe pcwe pcsel regwe wbsel asrc aluop[1:0]
    localparam logic [10:0] C_NONE   = 11'b0_0_0_0_0_0_0_0_0_00;
    localparam logic [10:0] C_F_WAIT = 11'b1_0_0_0_0_0_0_0_0_00;
    localparam logic [10:0] C_F_RDY  = 11'b1_0_0_1_0_0_0_0_0_00;
    localparam logic [10:0] C_EX_R   = 11'b0_0_0_0_0_0_0_0_0_10;
    localparam logic [10:0] C_EX_M   = 11'b0_0_0_0_0_0_0_0_1_00;
    localparam logic [10:0] C_EX_BT  = 11'b0_0_0_0_1_1_0_0_0_01;
    localparam logic [10:0] C_EX_BN  = 11'b0_0_0_0_1_0_0_0_0_01;
    localparam logic [10:0] C_M_LD   = 11'b1_0_1_0_0_0_0_0_0_00;
    localparam logic [10:0] C_M_SDW  = 11'b1_1_1_0_0_0_0_0_0_00;
    localparam logic [10:0] C_M_SDR  = 11'b1_1_1_0_1_0_0_0_0_00;
    localparam logic [10:0] C_WB_R   = 11'b0_0_0_0_1_0_1_0_0_00;
    localparam logic [10:0] C_WB_LD  = 11'b0_0_0_0_1_0_1_1_0_00;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_SLL  = 32'h002091B3;
    localparam logic [31:0] I_ANDA = 32'h4020F1B3;
    localparam logic [31:0] I_LD   = 32'h00813283;
    localparam logic [31:0] I_LD6  = 32'h00816283;
    localparam logic [31:0] I_SD   = 32'h00513823;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BAD  = 32'hFE950800;

    logic [10:0] ctrl_obs;
    assign ctrl_obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel,
                       reg_we, wb_sel, alu_src, alu_op};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .state     (state),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .retired   (retired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: apply inputs, let them settle, check, advance one cycle.
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input logic [2:0] exp_state, input logic [10:0] exp_ctrl);
        mem_ready = rdy;
        alu_zero  = z;
        #1;
        check({tag, ".state"}, 64'(state), 64'(exp_state));
        check({tag, ".ctrl"}, 64'(ctrl_obs), 64'(exp_ctrl));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        #2;
        check("rst.state", 64'(state), 64'(S_F));
        check("rst.ctrl", 64'(ctrl_obs), 64'(C_NONE));
        check("rst.illegal", 64'(illegal), 64'd0);
        check("rst.bus_err", 64'(bus_err), 64'd0);
        check("rst.retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_rtype(input string tag, input logic [31:0] ins);
        instr = ins;
        cyc({tag, ".f"}, 1'b1, 1'b0, S_F, C_F_RDY);
        cyc({tag, ".d"}, 1'b0, 1'b0, S_D, C_NONE);
        cyc({tag, ".e"}, 1'b0, 1'b0, S_E, C_EX_R);
        cyc({tag, ".w"}, 1'b0, 1'b0, S_W, C_WB_R);
    endtask

    task automatic run_trap(input string tag, input logic [31:0] ins, input logic [31:0] ret_exp);
        instr = ins;
        cyc({tag, ".f"}, 1'b1, 1'b0, S_F, C_F_RDY);
        cyc({tag, ".d"}, 1'b0, 1'b0, S_D, C_NONE);
        cyc({tag, ".t0"}, 1'b1, 1'b1, S_T, C_NONE);
        cyc({tag, ".t1"}, 1'b1, 1'b0, S_T, C_NONE);
        check({tag, ".illegal"}, 64'(illegal), 64'd1);
        check({tag, ".bus_err"}, 64'(bus_err), 64'd0);
        check({tag, ".retired"}, 64'(retired), 64'(ret_exp));
    endtask

    initial begin
        instr = I_ADD;
        do_reset();

        // add: F=1 -> WB on cycle 4, retired 0->1
        run_rtype("add", I_ADD);
        check("add.retired", 64'(retired), 64'd1);

        // ld with F=1, data ready after 3 waits
        instr = I_LD;
        cyc("ld.f", 1'b1, 1'b0, S_F, C_F_RDY);
        cyc("ld.d", 1'b0, 1'b0, S_D, C_NONE);
        cyc("ld.e", 1'b0, 1'b0, S_E, C_EX_M);
        for (int i = 0; i < 3; i++) cyc("ld.mw", 1'b0, 1'b0, S_M, C_M_LD);
        cyc("ld.mr", 1'b1, 1'b0, S_M, C_M_LD);
        cyc("ld.w", 1'b0, 1'b0, S_W, C_WB_LD);
        check("ld.retired", 64'(retired), 64'd2);

        // sd with a fetch wait and one data wait
        instr = I_SD;
        cyc("sd.fw", 1'b0, 1'b0, S_F, C_F_WAIT);
        cyc("sd.f", 1'b1, 1'b0, S_F, C_F_RDY);
        cyc("sd.d", 1'b0, 1'b0, S_D, C_NONE);
        cyc("sd.e", 1'b0, 1'b0, S_E, C_EX_M);
        cyc("sd.mw", 1'b0, 1'b0, S_M, C_M_SDW);
        cyc("sd.mr", 1'b1, 1'b0, S_M, C_M_SDR);
        check("sd.next", 64'(state), 64'(S_F));
        check("sd.retired", 64'(retired), 64'd3);

        // beq taken then not taken; mem_ready high while no request is ignored
        instr = I_BEQ;
        cyc("beqt.f", 1'b1, 1'b0, S_F, C_F_RDY);
        cyc("beqt.d", 1'b1, 1'b1, S_D, C_NONE);
        cyc("beqt.e", 1'b1, 1'b1, S_E, C_EX_BT);
        check("beqt.retired", 64'(retired), 64'd4);
        cyc("beqn.f", 1'b1, 1'b0, S_F, C_F_RDY);
        cyc("beqn.d", 1'b0, 1'b0, S_D, C_NONE);
        cyc("beqn.e", 1'b0, 1'b0, S_E, C_EX_BN);
        check("beqn.retired", 64'(retired), 64'd5);

        run_rtype("sub", I_SUB);
        run_rtype("and", I_AND);
        run_rtype("or", I_OR);
        check("rtype.retired", 64'(retired), 64'd8);

        // Illegal encodings trap without retiring
        run_trap("bad", I_BAD, 32'd8);
        rst_n = 1'b0;
        #1;
        check("bad.rst.state", 64'(state), 64'(S_F));
        check("bad.rst.illegal", 64'(illegal), 64'd0);
        do_reset();
        run_trap("ld6", I_LD6, 32'd0);
        do_reset();
        run_trap("sll", I_SLL, 32'd0);
        do_reset();
        run_trap("and_alt", I_ANDA, 32'd0);

        // Fetch timeout: 16 request cycles then TRAP with bus_err
        do_reset();
        for (int i = 0; i < 16; i++) cyc("to.fw", 1'b0, 1'b0, S_F, C_F_WAIT);
        check("to.state", 64'(state), 64'(S_T));
        check("to.bus_err", 64'(bus_err), 64'd1);
        check("to.illegal", 64'(illegal), 64'd0);
        check("to.ctrl", 64'(ctrl_obs), 64'(C_NONE));
        check("to.retired", 64'(retired), 64'd0);

        // Ready on the last allowed data cycle wins over the timeout
        do_reset();
        instr = I_LD;
        cyc("edge.f", 1'b1, 1'b0, S_F, C_F_RDY);
        cyc("edge.d", 1'b0, 1'b0, S_D, C_NONE);
        cyc("edge.e", 1'b0, 1'b0, S_E, C_EX_M);
        for (int i = 0; i < 15; i++) cyc("edge.mw", 1'b0, 1'b0, S_M, C_M_LD);
        cyc("edge.mr", 1'b1, 1'b0, S_M, C_M_LD);
        cyc("edge.w", 1'b0, 1'b0, S_W, C_WB_LD);
        check("edge.bus_err", 64'(bus_err), 64'd0);
        check("edge.retired", 64'(retired), 64'd1);

        // Reset asserted mid-MEM of a ld
        instr = I_LD;
        cyc("mr.f", 1'b1, 1'b0, S_F, C_F_RDY);
        cyc("mr.d", 1'b0, 1'b0, S_D, C_NONE);
        cyc("mr.e", 1'b0, 1'b0, S_E, C_EX_M);
        cyc("mr.mw", 1'b0, 1'b0, S_M, C_M_LD);
        rst_n = 1'b0;
        #1;
        check("mr.rst.state", 64'(state), 64'(S_F));
        check("mr.rst.ctrl", 64'(ctrl_obs), 64'(C_NONE));
        check("mr.rst.retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("mr.refetch", 1'b0, 1'b0, S_F, C_F_WAIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
